// File: rtl/rom_stream_reader.sv
// Burst read engine in front of a fixed-latency ROM. It accepts (addr, len) requests and
// returns the ROM words as a valid/ready stream with a last marker, without losing words.
module rom_stream_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int LEN_WIDTH     = 8,
  parameter int ROM_LATENCY   = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic [LEN_WIDTH-1:0]     i_req_len,
  output logic [ADDRESS_WIDTH-1:0] o_rom_address,
  input  logic [DATA_WIDTH-1:0]    i_rom_read_data,
  output logic                     o_dat_valid,
  input  logic                     i_dat_ready,
  output logic [DATA_WIDTH-1:0]    o_dat_data,
  output logic                     o_dat_last,
  output logic                     o_busy
);

  localparam int STAGES = ROM_LATENCY + 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int USE_W  = $clog2(STAGES + FIFO_DEPTH + 1);

  localparam logic [USE_W-1:0]         DEPTH_U  = USE_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]         DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]         PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LEN_WIDTH:0]       REM_ONE  = (LEN_WIDTH + 1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e                   state_q;
  logic                     req_ready_q;
  logic                     busy_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] rom_addr_q;
  logic [LEN_WIDTH:0]       remaining_q;

  // Stage 0 tracks the address currently on o_rom_address; the last stage marks the
  // cycle in which i_rom_read_data carries that word.
  logic [STAGES-1:0]        pipe_vld_q;
  logic [STAGES-1:0]        pipe_last_q;

  logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    fifo_last_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         fifo_count_q;
  logic [CNT_W-1:0]         fifo_count_d;

  logic                     req_fire;
  logic                     dat_valid;
  logic                     push;
  logic                     pop;
  logic                     issue;
  logic                     issue_last;
  logic [USE_W-1:0]         inflight;
  logic [USE_W-1:0]         credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight = inflight + USE_W'(pipe_vld_q[i]);
    end
    req_fire     = i_req_valid && req_ready_q;
    dat_valid    = (fifo_count_q != '0);
    pop          = dat_valid && i_dat_ready;
    push         = pipe_vld_q[STAGES-1];
    // A word leaving the FIFO this cycle frees its slot for the word issued this cycle.
    credit_used  = inflight + USE_W'(fifo_count_q) - USE_W'(pop);
    issue        = (state_q == S_ISSUE) && (credit_used < DEPTH_U);
    issue_last   = (remaining_q == REM_ONE);
    fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      rom_addr_q   <= '0;
      remaining_q  <= '0;
      pipe_vld_q   <= '0;
      pipe_last_q  <= '0;
      fifo_last_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      pipe_vld_q   <= {pipe_vld_q[STAGES-2:0], issue};
      pipe_last_q  <= {pipe_last_q[STAGES-2:0], issue && issue_last};
      fifo_count_q <= fifo_count_d;

      if (issue) begin
        rom_addr_q  <= addr_q;
        addr_q      <= addr_q + ADDR_ONE;
        remaining_q <= remaining_q - REM_ONE;
      end

      if (push) begin
        fifo_last_q[wr_ptr_q] <= pipe_last_q[STAGES-1];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end

      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            state_q     <= S_ISSUE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= i_req_addr;
            remaining_q <= {1'b0, i_req_len} + REM_ONE;
          end
        end
        S_ISSUE: begin
          if (issue && issue_last) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && fifo_last_q[rd_ptr_q]) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the data storage has no reset; outputs are gated by o_dat_valid, so stale
  // contents are never observable and the array maps onto plain RAM/flops without reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= i_rom_read_data;
    end
  end

  assign o_req_ready   = req_ready_q;
  assign o_busy        = busy_q;
  assign o_rom_address = rom_addr_q;
  assign o_dat_valid   = dat_valid;
  assign o_dat_data    = dat_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign o_dat_last    = dat_valid && fifo_last_q[rd_ptr_q];

  // The credit rule must make a push into a full FIFO without a matching pop impossible.
  fifo_no_overflow: assert property (
    @(posedge i_clk) disable iff (i_rst)
      !(push && !pop && (fifo_count_q == DEPTH_C))
  );

endmodule
